// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
//
// Decode-to-execute pipeline register. It holds one decoded instruction and
// selects the ALU operands from rs1/PC and rs2/immediate. It resolves
// EX/MEM and MEM/WB bypasses and guards against load-use hazards.
//
// Build option: `ID_EX_FORWARD_EN
//   defined   : operand forwarding, stall refresh, load-use hazard only.
//   undefined : operands come from stored data only. ID stalls while any
//               in-flight writer (held entry, EX/MEM, MEM/WB) targets one
//               of its non-zero source registers.
//
// Ports
//   clk, rst            rising-edge clock, synchronous active-high reset
//   id_valid/id_ready   ID -> stage handshake
//   id_*                decoded instruction fields from ID
//   flush               kill the held entry and refuse ID this cycle
//   exm_*, wb_*         EX/MEM and MEM/WB writeback (forwarding sources)
//   ex_valid/ex_ready   stage -> EX handshake
//   alu_op1/alu_op2     ALU operands (combinational from the forwarding muxes)
//   alu_func/funct7/funct3, ex_store_data, ex_rd_addr, ex_reg_write,
//   ex_mem_read, ex_mem_write   registered instruction fields for EX
// ---------------------------------------------------------------------------
module id_ex_stage #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             id_valid,
    output logic             id_ready,
    input  logic [WIDTH-1:0] id_pc,
    input  logic [WIDTH-1:0] id_rs1_data,
    input  logic [WIDTH-1:0] id_rs2_data,
    input  logic [WIDTH-1:0] id_imm,
    input  logic [4:0]       id_rs1_addr,
    input  logic [4:0]       id_rs2_addr,
    input  logic [4:0]       id_rd_addr,
    input  logic [3:0]       id_alu_func,
    input  logic [6:0]       id_funct7,
    input  logic [2:0]       id_funct3,
    input  logic             id_op1_sel,
    input  logic             id_op2_sel,
    input  logic             id_reg_write,
    input  logic             id_mem_read,
    input  logic             id_mem_write,

    input  logic             flush,

    input  logic             exm_reg_write,
    input  logic [4:0]       exm_rd_addr,
    input  logic [WIDTH-1:0] exm_result,
    input  logic             wb_reg_write,
    input  logic [4:0]       wb_rd_addr,
    input  logic [WIDTH-1:0] wb_result,

    output logic             ex_valid,
    input  logic             ex_ready,
    output logic [WIDTH-1:0] alu_op1,
    output logic [WIDTH-1:0] alu_op2,
    output logic [3:0]       alu_func,
    output logic [6:0]       funct7,
    output logic [2:0]       funct3,
    output logic [WIDTH-1:0] ex_store_data,
    output logic [4:0]       ex_rd_addr,
    output logic             ex_reg_write,
    output logic             ex_mem_read,
    output logic             ex_mem_write
);

    // Handshake: a side transfers on a rising edge where its valid and ready
    // are both high. valid never depends on ready. Once raised, ex_valid and
    // the entry stay stable until EX takes them or a flush kills them.
    // id_ready is combinational and is low whenever flush is high.

    // Held entry
    logic             valid;
    logic [WIDTH-1:0] held_pc;
    logic [WIDTH-1:0] held_rs1_data;
    logic [WIDTH-1:0] held_rs2_data;
    logic [WIDTH-1:0] held_imm;
    logic [4:0]       held_rs1_addr;
    logic [4:0]       held_rs2_addr;
    logic [4:0]       held_rd_addr;
    logic [3:0]       held_alu_func;
    logic [6:0]       held_funct7;
    logic [2:0]       held_funct3;
    logic             held_op1_sel;
    logic             held_op2_sel;
    logic             held_reg_write;
    logic             held_mem_read;
    logic             held_mem_write;

    logic [WIDTH-1:0] rs1_fwd;
    logic [WIDTH-1:0] rs2_fwd;
    logic             hazard;
    logic             in_xfer;
    logic             out_xfer;

`ifdef ID_EX_FORWARD_EN
    // EX/MEM is the younger producer and so takes priority over MEM/WB.
    // x0 is hard-wired to zero and must never pick up a bypassed value.
    always_comb begin
        rs1_fwd = held_rs1_data;
        if (held_rs1_addr != 5'd0) begin
            if (exm_reg_write && exm_rd_addr == held_rs1_addr)
                rs1_fwd = exm_result;
            else if (wb_reg_write && wb_rd_addr == held_rs1_addr)
                rs1_fwd = wb_result;
        end
    end

    always_comb begin
        rs2_fwd = held_rs2_data;
        if (held_rs2_addr != 5'd0) begin
            if (exm_reg_write && exm_rd_addr == held_rs2_addr)
                rs2_fwd = exm_result;
            else if (wb_reg_write && wb_rd_addr == held_rs2_addr)
                rs2_fwd = wb_result;
        end
    end

    // Load-use: the load data only exists at MEM/WB, so a dependent
    // instruction must wait one bubble behind the load. The check ignores the
    // operand selects on purpose; an extra stall is harmless.
    always_comb begin
        hazard = valid && held_mem_read && (held_rd_addr != 5'd0) &&
                 ((held_rd_addr == id_rs1_addr) || (held_rd_addr == id_rs2_addr));
    end
`else
    logic rs1_busy;
    logic rs2_busy;
    logic unused_results;

    always_comb begin
        rs1_fwd = held_rs1_data;
        rs2_fwd = held_rs2_data;
    end

    // Without bypassing, ID waits until every in-flight writer of its
    // sources has reached the register file.
    always_comb begin
        rs1_busy = (id_rs1_addr != 5'd0) &&
                   ((valid && held_reg_write && held_rd_addr == id_rs1_addr) ||
                    (exm_reg_write && exm_rd_addr == id_rs1_addr) ||
                    (wb_reg_write && wb_rd_addr == id_rs1_addr));
        rs2_busy = (id_rs2_addr != 5'd0) &&
                   ((valid && held_reg_write && held_rd_addr == id_rs2_addr) ||
                    (exm_reg_write && exm_rd_addr == id_rs2_addr) ||
                    (wb_reg_write && wb_rd_addr == id_rs2_addr));
        hazard   = rs1_busy || rs2_busy;
    end

    // Writeback values are only needed when bypassing is built in.
    assign unused_results = ^{exm_result, wb_result};
`endif

    assign id_ready = !flush && !hazard && (!valid || ex_ready);
    assign in_xfer  = id_valid && id_ready;
    assign out_xfer = valid && ex_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid          <= 1'b0;
            held_pc        <= '0;
            held_rs1_data  <= '0;
            held_rs2_data  <= '0;
            held_imm       <= '0;
            held_rs1_addr  <= '0;
            held_rs2_addr  <= '0;
            held_rd_addr   <= '0;
            held_alu_func  <= '0;
            held_funct7    <= '0;
            held_funct3    <= '0;
            held_op1_sel   <= 1'b0;
            held_op2_sel   <= 1'b0;
            held_reg_write <= 1'b0;
            held_mem_read  <= 1'b0;
            held_mem_write <= 1'b0;
        end else if (flush) begin
            // id_ready is low during flush, so no capture can race this.
            valid <= 1'b0;
        end else if (in_xfer) begin
            valid          <= 1'b1;
            held_pc        <= id_pc;
            held_rs1_data  <= id_rs1_data;
            held_rs2_data  <= id_rs2_data;
            held_imm       <= id_imm;
            held_rs1_addr  <= id_rs1_addr;
            held_rs2_addr  <= id_rs2_addr;
            held_rd_addr   <= id_rd_addr;
            held_alu_func  <= id_alu_func;
            held_funct7    <= id_funct7;
            held_funct3    <= id_funct3;
            held_op1_sel   <= id_op1_sel;
            held_op2_sel   <= id_op2_sel;
            held_reg_write <= id_reg_write;
            held_mem_read  <= id_mem_read;
            held_mem_write <= id_mem_write;
        end else if (out_xfer) begin
            valid <= 1'b0;
        end else if (valid) begin
`ifdef ID_EX_FORWARD_EN
            // Stalled: latch the bypassed values so a producer that retires
            // during the stall does not take its result with it.
            held_rs1_data <= rs1_fwd;
            held_rs2_data <= rs2_fwd;
`endif
        end
    end

    assign ex_valid      = valid;
    assign alu_op1       = held_op1_sel ? held_pc  : rs1_fwd;
    assign alu_op2       = held_op2_sel ? held_imm : rs2_fwd;
    assign ex_store_data = rs2_fwd;
    assign alu_func      = held_alu_func;
    assign funct7        = held_funct7;
    assign funct3        = held_funct3;
    assign ex_rd_addr    = held_rd_addr;
    assign ex_reg_write  = held_reg_write;
    assign ex_mem_read   = held_mem_read;
    assign ex_mem_write  = held_mem_write;

endmodule

// File: tb/tb_id_ex_stage.sv
// ---------------------------------------------------------------------------
// tb_id_ex_stage
//
// Directed bench for id_ex_stage. It covers the shared behaviour in either
// build plus the forwarding-specific or stall-on-writer-specific sequences,
// chosen by `ID_EX_FORWARD_EN.
// ---------------------------------------------------------------------------
module tb_id_ex_stage;
    localparam int W = 32;

    logic         clk;
    logic         rst;
    logic         id_valid;
    logic         id_ready;
    logic [W-1:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]   id_rs1_addr, id_rs2_addr, id_rd_addr;
    logic [3:0]   id_alu_func;
    logic [6:0]   id_funct7;
    logic [2:0]   id_funct3;
    logic         id_op1_sel, id_op2_sel;
    logic         id_reg_write, id_mem_read, id_mem_write;
    logic         flush;
    logic         exm_reg_write;
    logic [4:0]   exm_rd_addr;
    logic [W-1:0] exm_result;
    logic         wb_reg_write;
    logic [4:0]   wb_rd_addr;
    logic [W-1:0] wb_result;
    logic         ex_valid;
    logic         ex_ready;
    logic [W-1:0] alu_op1, alu_op2, ex_store_data;
    logic [3:0]   alu_func;
    logic [6:0]   funct7;
    logic [2:0]   funct3;
    logic [4:0]   ex_rd_addr;
    logic         ex_reg_write, ex_mem_read, ex_mem_write;

    int total;
    int bad;
    logic [W-1:0] exp_q[$];

    id_ex_stage #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_ready(id_ready),
        .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
        .id_imm(id_imm),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr), .id_rd_addr(id_rd_addr),
        .id_alu_func(id_alu_func), .id_funct7(id_funct7), .id_funct3(id_funct3),
        .id_op1_sel(id_op1_sel), .id_op2_sel(id_op2_sel),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .flush(flush),
        .exm_reg_write(exm_reg_write), .exm_rd_addr(exm_rd_addr), .exm_result(exm_result),
        .wb_reg_write(wb_reg_write), .wb_rd_addr(wb_rd_addr), .wb_result(wb_result),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .alu_op1(alu_op1), .alu_op2(alu_op2),
        .alu_func(alu_func), .funct7(funct7), .funct3(funct3),
        .ex_store_data(ex_store_data), .ex_rd_addr(ex_rd_addr),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        id_valid = 0; id_pc = '0; id_rs1_data = '0; id_rs2_data = '0; id_imm = '0;
        id_rs1_addr = 0; id_rs2_addr = 0; id_rd_addr = 0;
        id_alu_func = 0; id_funct7 = 0; id_funct3 = 0;
        id_op1_sel = 0; id_op2_sel = 0;
        id_reg_write = 0; id_mem_read = 0; id_mem_write = 0;
        flush = 0;
        exm_reg_write = 0; exm_rd_addr = 0; exm_result = '0;
        wb_reg_write = 0; wb_rd_addr = 0; wb_result = '0;
        ex_ready = 1;
    endtask

    // Present one instruction on the ID side, then let combinational logic settle.
    task automatic send(input logic [W-1:0] pc, input logic [W-1:0] rs1d,
                        input logic [W-1:0] rs2d, input logic [W-1:0] imm,
                        input logic [4:0] rs1a, input logic [4:0] rs2a,
                        input logic [4:0] rda, input logic op1s, input logic op2s,
                        input logic rw, input logic mr, input logic mw);
        id_valid = 1; id_pc = pc; id_rs1_data = rs1d; id_rs2_data = rs2d; id_imm = imm;
        id_rs1_addr = rs1a; id_rs2_addr = rs2a; id_rd_addr = rda;
        id_alu_func = 0; id_funct7 = 0; id_funct3 = 0;
        id_op1_sel = op1s; id_op2_sel = op2s;
        id_reg_write = rw; id_mem_read = mr; id_mem_write = mw;
        #1;
    endtask

    initial begin
        total = 0;
        bad = 0;
        idle_inputs();
        rst = 1;
        tick();
        tick();
        rst = 0;
        #1;

        // reset state
        check("rst_ex_valid", ex_valid, 0);
        check("rst_op1", alu_op1, 0);
        check("rst_op2", alu_op2, 0);
        check("rst_store", ex_store_data, 0);
        check("rst_ctrl", {alu_func, funct7, funct3, ex_rd_addr,
                           ex_reg_write, ex_mem_read, ex_mem_write}, 0);
        check("rst_id_ready", id_ready, 1);

        // ADD x3,x1,x2 with nothing in flight, non-zero function fields
        send(32'h0, 32'd5, 32'd7, 32'h0, 5'd1, 5'd2, 5'd3, 0, 0, 1, 0, 0);
        id_alu_func = 4'h2; id_funct7 = 7'h20; id_funct3 = 3'h5;
        #1;
        check("add_id_ready", id_ready, 1);
        tick();
        id_valid = 0;
        #1;
        check("add_ex_valid", ex_valid, 1);
        check("add_op1", alu_op1, 5);
        check("add_op2", alu_op2, 7);
        check("add_store", ex_store_data, 7);
        check("add_rd", ex_rd_addr, 3);
        check("add_ctrl", {alu_func, funct7, funct3, ex_reg_write}, {4'h2, 7'h20, 3'h5, 1'b1});

        // backpressure: EX not ready, ID must be refused and entry held
        ex_ready = 0;
        send(32'h0, 32'h11, 32'h0, 32'h0, 5'd4, 5'd0, 5'd6, 0, 0, 1, 0, 0);
        check("bp_id_ready", id_ready, 0);
        tick();
        check("bp_ex_valid", ex_valid, 1);
        check("bp_op1_held", alu_op1, 5);
        check("bp_rd_held", ex_rd_addr, 3);
        id_valid = 0;
        ex_ready = 1;
        #1;

`ifndef ID_EX_FORWARD_EN
        // held entry writes x3; ID reading x3 must wait one bubble
        send(32'h0, 32'h33, 32'h0, 32'h10, 5'd3, 5'd0, 5'd7, 0, 1, 1, 0, 0);
        check("held_wr_hz", id_ready, 0);
        tick();
        check("held_wr_bubble", ex_valid, 0);
        check("held_wr_clear", id_ready, 1);
        tick();
        id_valid = 0;
        #1;
        check("held_wr_valid", ex_valid, 1);
        check("held_wr_op1", alu_op1, 32'h33);
        check("held_wr_op2_imm", alu_op2, 32'h10);
        check("held_wr_rd", ex_rd_addr, 7);

        // EX/MEM writer of x1, then MEM/WB writer of x2, block a load reading both
        exm_reg_write = 1; exm_rd_addr = 5'd1; exm_result = 32'hdead;
        send(32'h100, 32'hA, 32'hB, 32'h0, 5'd1, 5'd2, 5'd8, 1, 0, 1, 1, 0);
        check("exm_hz", id_ready, 0);
        tick();
        check("exm_hz_bubble", ex_valid, 0);
        check("exm_hz_hold", id_ready, 0);
        exm_reg_write = 0;
        wb_reg_write = 1; wb_rd_addr = 5'd2; wb_result = 32'hbeef;
        #1;
        check("wb_hz", id_ready, 0);
        wb_reg_write = 0;
        #1;
        check("no_writer", id_ready, 1);
        tick();
        id_valid = 0;
        #1;
        check("lw_valid", ex_valid, 1);
        check("lw_op1_pc", alu_op1, 32'h100);
        check("lw_op2", alu_op2, 32'hB);
        check("lw_mem_read", ex_mem_read, 1);
        check("lw_rd", ex_rd_addr, 8);
`endif

        // writers targeting x0 never stall a reader of x0; in+out same edge
        exm_reg_write = 1; exm_rd_addr = 5'd0; exm_result = 32'd55;
        wb_reg_write = 1; wb_rd_addr = 5'd0; wb_result = 32'd55;
        send(32'h0, 32'h66, 32'h77, 32'h0, 5'd0, 5'd0, 5'd9, 0, 0, 0, 0, 1);
        check("x0_id_ready", id_ready, 1);
        tick();
        id_valid = 0;
        #1;
        check("x0_rd", ex_rd_addr, 9);
        check("x0_op1_stored", alu_op1, 32'h66);
        check("x0_op2_stored", alu_op2, 32'h77);
        check("sw_mem_write", ex_mem_write, 1);
        exm_reg_write = 0; wb_reg_write = 0;

        // flush with entry valid and ID presenting
        ex_ready = 0;
        flush = 1;
        send(32'h0, 32'h44, 32'h0, 32'h0, 5'd4, 5'd0, 5'd10, 0, 0, 1, 0, 0);
        check("flush_id_ready", id_ready, 0);
        tick();
        flush = 0;
        id_valid = 0;
        #1;
        check("flush_ex_valid", ex_valid, 0);
        check("flush_not_captured", ex_rd_addr, 9);

        // back-to-back stream, one per cycle
        ex_ready = 1;
        for (int i = 0; i < 4; i++) begin
            send(32'h0, 32'h100 + 32'(i), 32'h0, 32'h0, 5'd0, 5'd0, 5'(11 + i), 0, 0, 1, 0, 0);
            check("b2b_id_ready", id_ready, 1);
            exp_q.push_back(32'h100 + 32'(i));
            tick();
            check("b2b_ex_valid", ex_valid, 1);
            if (exp_q.size() != 0) check("b2b_op1", alu_op1, exp_q.pop_front());
        end
        id_valid = 0;
        tick();
        check("b2b_drain", ex_valid, 0);

`ifdef ID_EX_FORWARD_EN
        // forward from EX/MEM
        exm_reg_write = 1; exm_rd_addr = 5'd1; exm_result = 32'd100;
        send(32'h0, 32'd5, 32'd7, 32'h0, 5'd1, 5'd2, 5'd3, 0, 0, 1, 0, 0);
        check("fwd_id_ready", id_ready, 1);
        tick();
        id_valid = 0;
        #1;
        check("fwd_valid", ex_valid, 1);
        check("fwd_op1", alu_op1, 100);
        check("fwd_op2", alu_op2, 7);

        // priority: EX/MEM over MEM/WB
        ex_ready = 0;
        exm_rd_addr = 5'd2; exm_result = 32'd9;
        wb_reg_write = 1; wb_rd_addr = 5'd2; wb_result = 32'd4;
        #1;
        check("prio_op2", alu_op2, 9);
        check("prio_store", ex_store_data, 9);
        exm_reg_write = 0;
        #1;
        check("wb_only_op2", alu_op2, 4);
        wb_reg_write = 0;
        ex_ready = 1;
        #1;

        // load-use
        send(32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd5, 0, 0, 1, 1, 0);
        tick();
        send(32'h0, 32'h0, 32'd2, 32'h0, 5'd5, 5'd1, 5'd6, 0, 0, 1, 0, 0);
        check("lu_id_ready", id_ready, 0);
        tick();
        check("lu_bubble", ex_valid, 0);
        check("lu_clear", id_ready, 1);
        wb_reg_write = 1; wb_rd_addr = 5'd5; wb_result = 32'h1234;
        tick();
        id_valid = 0;
        #1;
        check("lu_valid", ex_valid, 1);
        check("lu_op1", alu_op1, 32'h1234);
        check("lu_op2", alu_op2, 2);
        wb_reg_write = 0;

        // stall refresh: MEM/WB x1=77 present for one cycle only
        send(32'h0, 32'h0, 32'h0, 32'h0, 5'd1, 5'd0, 5'd7, 0, 0, 1, 0, 0);
        tick();
        id_valid = 0;
        ex_ready = 0;
        wb_reg_write = 1; wb_rd_addr = 5'd1; wb_result = 32'd77;
        #1;
        check("refresh_c1", alu_op1, 77);
        tick();
        wb_reg_write = 0;
        #1;
        check("refresh_c2", alu_op1, 77);
        tick();
        check("refresh_c3", alu_op1, 77);
        ex_ready = 1;
        tick();
`endif

        // reset while stalled discards the entry
        send(32'h0, 32'h99, 32'h0, 32'h0, 5'd0, 5'd0, 5'd12, 0, 0, 1, 0, 0);
        tick();
        id_valid = 0;
        ex_ready = 0;
        #1;
        check("pre_rst_valid", ex_valid, 1);
        rst = 1;
        tick();
        check("mid_rst_valid", ex_valid, 0);
        check("mid_rst_op1", alu_op1, 0);
        check("mid_rst_rd", ex_rd_addr, 0);
        rst = 0;
        #1;
        check("post_rst_ready", id_ready, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard stop in case the sequence above ever stalls.
    initial begin
        #100000;
        $display("FAIL timeout: got=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Decode-to-execute pipeline register for the in-order core. It captures one decoded instruction from the ID stage and selects the ALU operands from rs1/PC and rs2/immediate. It applies EX/MEM and MEM/WB forwarding, detects load-use hazards, and presents `alu_op1`/`alu_op2`/`alu_func`/`funct7`/`funct3` directly to the execute-stage ALU. Flow control is valid/ready in both directions, with a branch flush.

## Interface
- `WIDTH`, 32, datapath width.
- `clk` in 1, rising-edge clock.
- `rst` in 1, synchronous, active-high reset.
- `id_valid` in 1, ID presents an instruction.
- `id_ready` out 1, stage accepts the instruction this cycle.
- `id_pc`, `id_rs1_data`, `id_rs2_data`, `id_imm` in WIDTH each, PC, register file read data and immediate.
- `id_rs1_addr`, `id_rs2_addr`, `id_rd_addr` in 5 each, register indices.
- `id_alu_func` in 4, ALU operation code, passed through.
- `id_funct7` in 7, passed through.
- `id_funct3` in 3, passed through.
- `id_op1_sel` in 1, 0 = rs1, 1 = PC.
- `id_op2_sel` in 1, 0 = rs2, 1 = immediate.
- `id_reg_write`, `id_mem_read`, `id_mem_write` in 1 each, control bits.
- `flush` in 1, kill the held instruction and refuse ID input this cycle.
- `exm_reg_write` in 1, `exm_rd_addr` in 5, `exm_result` in WIDTH: EX/MEM forwarding source.
- `wb_reg_write` in 1, `wb_rd_addr` in 5, `wb_result` in WIDTH: MEM/WB forwarding source.
- `ex_valid` out 1, instruction presented to EX.
- `ex_ready` in 1, EX consumes this cycle.
- `alu_op1`, `alu_op2` out WIDTH, ALU operands.
- `alu_func` out 4, `funct7` out 7, `funct3` out 3: ALU controls.
- `ex_store_data` out WIDTH, forwarded rs2 value.
- `ex_rd_addr` out 5, `ex_reg_write` out 1, `ex_mem_read` out 1, `ex_mem_write` out 1.

## Operation
- **Storage.** One entry holds the raw rs1/rs2 data, all three addresses, PC, immediate, selects and controls, plus a `valid` bit.
- **Transfer rules.**
  - Out: when `ex_valid && ex_ready`.
  - In: when `id_valid && id_ready`.
  - `id_ready = !flush && !hazard && (!ex_valid || ex_ready)`.
- **Next valid.**
  - `flush`: 0.
  - Otherwise, when an ID transfer occurs: 1.
  - Otherwise, when an out transfer occurs: 0 (a bubble).
  - Otherwise: hold.
- **Forwarding.** Applied per source register addr, 0 never forwarded.
  - EX/MEM match (`exm_reg_write && exm_rd_addr==addr`) wins over a MEM/WB match; otherwise the stored value is used.
- **Refresh.** Each cycle the entry is valid and held (no transfer, no flush), the forwarded rs1/rs2 values are written back into the stored fields. A producer retiring during a stall therefore cannot lose its value.
- **Operand muxes.**
  - `alu_op1 = op1_sel ? pc : rs1_fwd`.
  - `alu_op2 = op2_sel ? imm : rs2_fwd`.
  - `ex_store_data = rs2_fwd`.
- **Hazard (load-use).** `ex_valid && ex_mem_read && ex_rd_addr!=0 && (ex_rd_addr==id_rs1_addr || ex_rd_addr==id_rs2_addr)`.
  - The comparison is conservative and ignores the select bits.
  - When the load leaves, a bubble is inserted. The dependent instruction enters next cycle and takes the load data via MEM/WB forwarding.
- **Simultaneous flush and `ex_ready`.** Flush wins and the entry is dropped. EX must itself ignore a transfer in a flush cycle.

## Timing
- Latency: an ID transfer at edge N gives `ex_valid` from N+1 onward.
- All outputs are taken from registers, except the forwarding/operand muxes, which are combinational from the `exm_*`/`wb_*` inputs.
- `id_ready` is combinational from `flush`, `ex_ready`, the ID addresses and the held entry.
- Reset values: `ex_valid`=0 and all stored fields 0. Consequently `alu_op1`=`alu_op2`=`ex_store_data`=0, `alu_func`=`funct7`=`funct3`=0, `ex_rd_addr`=0, `ex_reg_write`=`ex_mem_read`=`ex_mem_write`=0.
- `id_ready` is 1 the cycle after reset deasserts, unless `flush` is asserted.
- Reset mid-stall discards the entry and performs no refresh.
- Back-to-back throughput is one instruction per cycle when `ex_ready`=1 and there is no hazard.

## Configuration
- Macro: `ID_EX_FORWARD_EN`.
- Defined: forwarding, refresh and the load-use hazard behave as above.
- Undefined:
  - No forwarding muxes and no refresh; operands come from stored data only.
  - Hazard becomes: any non-zero `id_rs1_addr`/`id_rs2_addr` equal to a valid writer's rd, from the held entry (`ex_reg_write`), `exm_*` or `wb_*`.
  - ID therefore stalls until the value reaches the register file.

## Test plan
- **Forward from EX/MEM.** Reset, then ID `ADD x3,x1,x2` with rs1=5, rs2=7, while `exm` writes x1=100 → `alu_op1`=100, `alu_op2`=7, `ex_valid`=1 one cycle later.
- **Source priority.** `exm` and `wb` both target x2, with `exm_result`=9 and `wb_result`=4 → `alu_op2`=9. A target of x0 with value 55 → stored value used.
- **Load-use.** `LW x5` held, ID `ADD x6,x5,x1`, `ex_ready`=1 → `id_ready`=0 for one cycle. The bubble gives `ex_valid`=0. The ADD then enters with `wb` x5=0x1234 → `alu_op1`=0x1234.
- **Stall refresh.** `ex_ready`=0 for 3 cycles; `wb` x1=77 is present in cycle 1 only → `alu_op1` stays 77 through cycle 3.
- **Flush.** Flush asserted with the entry valid and `id_valid`=1 → `id_ready`=0, `ex_valid`=0 next cycle, the ID instruction is not captured.
- **Macro off.** `ID_EX_FORWARD_EN` undefined, `exm` writing x1, ID reads x1 → `id_ready`=0 until no writer matches.
